byte_unstriping: RTL and testbench
==================================

# byte_unstriping

Receive-side counterpart of the byte-striping stage: accepts 32-bit words from two lanes (`lane0`/`lane1`, each with its own valid) and reassembles them into a single in-order word stream. The stage sits directly downstream of byte-striping on the `clk_2f` domain. Each lane is buffered in a small FIFO to absorb inter-lane skew and bursty valids. An alignment state machine then drains the FIFOs strictly alternately, starting with lane 0.

## Interface
- `DATA_WIDTH`, 32, width of each lane word and of the output word
- `FIFO_DEPTH`, 4, entries per lane FIFO (power of two, ≥2)

- `clk_2f`  input  1  single clock; all state updates on its rising edge
- `reset_L`  input  1  reset, asynchronous, active-low
- `lane0`  input  DATA_WIDTH  lane 0 word (even positions of the original stream)
- `valid_0`  input  1  `lane0` holds a word this cycle
- `lane1`  input  DATA_WIDTH  lane 1 word (odd positions)
- `valid_1`  input  1  `lane1` holds a word this cycle
- `data_out`  output  DATA_WIDTH  reassembled word, registered
- `valid_out`  output  1  `data_out` valid this cycle, registered
- `aligned`  output  1  high while the state machine is in RUN
- `overflow_0`  output  1  sticky: a lane 0 word was dropped on a full FIFO
- `overflow_1`  output  1  sticky: same for lane 1

## Operation
- **Lane push**
  - `valid_x` = 1 writes `lane_x` into FIFO x at the edge.
  - Push on full with no simultaneous pop: the word is dropped, FIFO contents are unchanged, and `overflow_x` is set.
  - Push and pop in the same cycle on a full FIFO is legal. There is no drop and no overflow.
- **FSM, two states**
  - ALIGN (reset state): `valid_out` = 0 and nothing is popped until both FIFOs are non-empty.
  - ALIGN exit: at the edge where both FIFOs are non-empty, pop lane 0, drive its word on `data_out` with `valid_out` = 1, set `next_lane` = 1, and go to RUN.
  - RUN, FIFO[`next_lane`] non-empty: pop it, output the word with `valid_out` = 1, toggle `next_lane`.
  - RUN, FIFO[`next_lane`] empty: `valid_out` = 0, and `next_lane` does not change. The stage never skips a lane, so ordering is preserved.
  - RUN is left only by reset.
- **Empty-check timing:** FIFO emptiness is evaluated on registered pointers. A word pushed at edge N becomes poppable at edge N+1. There is no combinational bypass from the lane inputs to `data_out`.
- **Output hold:** when `valid_out` = 0, `data_out` holds its last value.
- **Reset assertion (including mid-stream)**
  - Asynchronously clears both FIFO pointers, which flushes their contents.
  - Returns the FSM to ALIGN with `next_lane` = 0.
  - Clears the `overflow` flags.
- **Reset values:** `data_out` = 0, `valid_out` = 0, `aligned` = 0, `overflow_0` = 0, `overflow_1` = 0.
- **Pointers:** width log2(FIFO_DEPTH)+1 bits, with the extra bit used for full/empty disambiguation. Pointers wrap modulo 2·FIFO_DEPTH.

## Timing
- **Latency:** one cycle from a lane push to `valid_out` when that lane's FIFO is empty and it is that lane's turn. Example: push at edge N gives output after edge N+1.
- **Throughput:** at most one word per cycle out. A sustained input of one word per lane every 2 cycles never overflows.
- **Skew tolerance:** lane 1 may lag lane 0 by up to FIFO_DEPTH words without loss.
- **Timing of `aligned`:** it rises on the same edge as the first `valid_out`.
- **Reset release:** the first push can be accepted on the first edge after `reset_L` deasserts.

## Structure
- Shared package `striping_pkg`:
  - `DATA_WIDTH` default
  - FSM state encoding: ALIGN = 1'b0, RUN = 1'b1
  - lane index constants `LANE0` = 0 and `LANE1` = 1, shared with the byte-striping stage
- One sub-module `lane_fifo`, instantiated twice:
  - parameterised by DATA_WIDTH and FIFO_DEPTH
  - push, pop, and head-data ports
  - registered `empty`/`full` outputs
  - asynchronous active-low reset
- The top level holds the FSM, `next_lane`, the output registers, and the sticky overflow flags.

## Test plan
- **In-order merge:** push `lane0` = FFFFFFFF, DDDDDDDD and `lane1` = EEEEEEEE, CCCCCCCC on the same cycles (every 2 cycles) → `data_out` = FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC in order; `aligned` rises with the first word.
- **Skew:** lane 1 words arrive 3 cycles after lane 0 (00000003 on lane 0, 00000004 on lane 1) → no output until 00000004 is pushed, then 00000003 followed by 00000004; no overflow.
- **Gap mid-stream:** after alignment, lane 1 valid is low for 4 cycles → `valid_out` = 0 during the gap and the FSM waits on lane 1; the next lane 1 word (99999999) is emitted before any further lane 0 word.
- **Overflow:** hold lane 1 idle and push 5 words on lane 0 with FIFO_DEPTH = 4 → the fifth word (00000009) is dropped, `overflow_0` = 1 and stays set; once lane 1 supplies words, the output shows only the first four lane 0 words interleaved.
- **Full with simultaneous push/pop:** lane 0 FIFO full and in RUN, with a lane 0 push coinciding with a lane 0 pop → no drop, `overflow_0` stays 0.
- **Reset mid-operation:** assert `reset_L` = 0 asynchronously between edges while both FIFOs hold data → all outputs go to 0 immediately; after release, stale words never appear and a fresh AAAAAAAA/BBBBBBBB pair realigns with AAAAAAAA first.

Source files
------------

// File: rtl/striping_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | striping_pkg : types and constants shared by the striping/unstriping stages |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+

package striping_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  typedef enum logic [0:0] {
    ALIGN = 1'b0,
    RUN   = 1'b1
  } align_state_e;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/lane_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lane_fifo : per-lane skew buffer with registered empty/full flags          |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+

module lane_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_2f,
  input  logic                  reset_L,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam int c_addr_w = $clog2(FIFO_DEPTH);
  localparam int c_ptr_w  = c_addr_w + 1;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_ptr_w-1:0]    w_wr_ptr_nxt;
  logic [c_ptr_w-1:0]    w_rd_ptr_nxt;
  logic                  r_empty;
  logic                  r_full;
  logic                  w_do_push;
  logic                  w_do_pop;

  // A pop in the same cycle frees a slot, so a push on full is still accepted.
  always_comb begin
    w_do_pop     = i_pop & ~r_empty;
    w_do_push    = i_push & (~r_full | w_do_pop);
    w_wr_ptr_nxt = r_wr_ptr + c_ptr_w'(w_do_push);
    w_rd_ptr_nxt = r_rd_ptr + c_ptr_w'(w_do_pop);
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      r_full   <= ((w_wr_ptr_nxt ^ w_rd_ptr_nxt) == {1'b1, {c_addr_w{1'b0}}});
    end
  end

  always_ff @(posedge clk_2f) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[c_addr_w-1:0]] <= i_push_data;
    end
  end

  assign o_head_data = r_mem[r_rd_ptr[c_addr_w-1:0]];
  assign o_empty     = r_empty;
  assign o_full      = r_full;

endmodule

`default_nettype wire

// File: rtl/byte_unstriping.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | byte_unstriping : merges two skewed lanes back into one in-order stream    |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+

module byte_unstriping
  import striping_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_2f,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] lane0,
  input  logic                  valid_0,
  input  logic [DATA_WIDTH-1:0] lane1,
  input  logic                  valid_1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  aligned,
  output logic                  overflow_0,
  output logic                  overflow_1
);

  align_state_e          r_state;
  align_state_e          w_state_nxt;
  logic                  r_next_lane;
  logic                  w_next_lane_nxt;
  logic                  w_load;
  logic                  w_sel;
  logic [1:0]            w_push;
  logic [1:0]            w_pop;
  logic [1:0]            w_empty;
  logic [1:0]            w_full;
  logic [DATA_WIDTH-1:0] w_lane_data [2];
  logic [DATA_WIDTH-1:0] w_head [2];
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic [1:0]            r_overflow;

  assign w_push             = {valid_1, valid_0};
  assign w_lane_data[LANE0] = lane0;
  assign w_lane_data[LANE1] = lane1;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_lane
      lane_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_lane_fifo (
        .clk_2f      (clk_2f),
        .reset_L     (reset_L),
        .i_push      (w_push[g]),
        .i_push_data (w_lane_data[g]),
        .i_pop       (w_pop[g]),
        .o_head_data (w_head[g]),
        .o_empty     (w_empty[g]),
        .o_full      (w_full[g])
      );
    end
  endgenerate

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= ALIGN;
      r_next_lane <= LANE0;
    end else begin
      r_state     <= w_state_nxt;
      r_next_lane <= w_next_lane_nxt;
    end
  end

  // Lanes are drained strictly alternately; an empty lane stalls rather than being skipped.
  always_comb begin
    w_state_nxt     = r_state;
    w_next_lane_nxt = r_next_lane;
    w_pop           = 2'b00;
    w_load          = 1'b0;
    w_sel           = LANE0;
    case (r_state)
      ALIGN: begin
        if (!w_empty[LANE0] && !w_empty[LANE1]) begin
          w_pop[LANE0]    = 1'b1;
          w_load          = 1'b1;
          w_sel           = LANE0;
          w_next_lane_nxt = LANE1;
          w_state_nxt     = RUN;
        end
      end
      RUN: begin
        if (!w_empty[r_next_lane]) begin
          w_pop[r_next_lane] = 1'b1;
          w_load             = 1'b1;
          w_sel              = r_next_lane;
          w_next_lane_nxt    = ~r_next_lane;
        end
      end
      default: begin
        w_state_nxt     = ALIGN;
        w_next_lane_nxt = LANE0;
      end
    endcase
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_overflow  <= 2'b00;
    end else begin
      if (w_load) begin
        r_data_out <= w_head[w_sel];
      end
      r_valid_out <= w_load;
      r_overflow  <= r_overflow | (w_push & w_full & ~w_pop);
    end
  end

  assign data_out   = r_data_out;
  assign valid_out  = r_valid_out;
  assign aligned    = (r_state == RUN);
  assign overflow_0 = r_overflow[LANE0];
  assign overflow_1 = r_overflow[LANE1];

endmodule

`default_nettype wire

// File: tb/tb_byte_unstriping.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_byte_unstriping : scoreboard bench with a queue-level lane merge model  |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+

module tb_byte_unstriping;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk_2f;
  logic          reset_L;
  logic [DW-1:0] lane0;
  logic          valid_0;
  logic [DW-1:0] lane1;
  logic          valid_1;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          aligned;
  logic          overflow_0;
  logic          overflow_1;

  byte_unstriping #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_2f     (clk_2f),
    .reset_L    (reset_L),
    .lane0      (lane0),
    .valid_0    (valid_0),
    .lane1      (lane1),
    .valid_1    (valid_1),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .aligned    (aligned),
    .overflow_0 (overflow_0),
    .overflow_1 (overflow_1)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  // Reference model: each lane is a bounded queue, output is the strict alternation.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] sb[$];
  bit            m_run;
  bit            m_next;
  bit            exp_valid;
  bit            exp_aligned;
  bit            exp_ovf0;
  bit            exp_ovf1;
  logic [DW-1:0] m_last;
  int            n_checks;
  int            n_fail;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    sb.delete();
    m_run       = 1'b0;
    m_next      = 1'b0;
    exp_valid   = 1'b0;
    exp_aligned = 1'b0;
    exp_ovf0    = 1'b0;
    exp_ovf1    = 1'b0;
    m_last      = '0;
  endtask

  // Drive one cycle of lane inputs and predict what the following edge produces.
  task automatic cycle(input bit v0, input logic [DW-1:0] d0, input bit v1, input logic [DW-1:0] d1);
    bit took0;
    bit took1;
    @(negedge clk_2f);
    valid_0 = v0;
    lane0   = d0;
    valid_1 = v1;
    lane1   = d1;
    took0   = 1'b0;
    took1   = 1'b0;
    if (!m_run) begin
      if (q0.size() > 0 && q1.size() > 0) begin
        took0  = 1'b1;
        m_run  = 1'b1;
        m_next = 1'b1;
      end
    end else if (!m_next && q0.size() > 0) begin
      took0  = 1'b1;
      m_next = 1'b1;
    end else if (m_next && q1.size() > 0) begin
      took1  = 1'b1;
      m_next = 1'b0;
    end
    if (took0) sb.push_back(q0.pop_front());
    if (took1) sb.push_back(q1.pop_front());
    exp_valid   = took0 | took1;
    exp_aligned = m_run;
    if (v0) begin
      if (q0.size() < DEPTH) q0.push_back(d0);
      else exp_ovf0 = 1'b1;
    end
    if (v1) begin
      if (q1.size() < DEPTH) q1.push_back(d1);
      else exp_ovf1 = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk_2f);
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    reset_L = 1'b0;
    model_reset();
    @(negedge clk_2f);
    reset_L = 1'b1;
  endtask

  // Monitor: samples after each active edge and consumes the scoreboard.
  initial begin
    logic [DW-1:0] w;
    forever begin
      @(posedge clk_2f);
      #2;
      check("valid_out", {31'b0, valid_out}, {31'b0, exp_valid});
      if (valid_out) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL data_out: got unexpected word %h, expected none", data_out);
        end else begin
          w = sb.pop_front();
          check("data_out", data_out, w);
          m_last = w;
        end
      end else begin
        check("data_hold", data_out, m_last);
      end
      check("aligned", {31'b0, aligned}, {31'b0, exp_aligned});
      check("overflow_0", {31'b0, overflow_0}, {31'b0, exp_ovf0});
      check("overflow_1", {31'b0, overflow_1}, {31'b0, exp_ovf1});
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_L  = 1'b0;
    valid_0  = 1'b0;
    valid_1  = 1'b0;
    lane0    = '0;
    lane1    = '0;
    model_reset();
    #12;
    check("rst_data_out", data_out, '0);
    check("rst_valid_out", {31'b0, valid_out}, '0);
    check("rst_aligned", {31'b0, aligned}, '0);
    check("rst_overflow_0", {31'b0, overflow_0}, '0);
    check("rst_overflow_1", {31'b0, overflow_1}, '0);
    @(negedge clk_2f);
    reset_L = 1'b1;

    // In-order merge, one word per lane every 2 cycles
    cycle(1'b1, 32'hFFFFFFFF, 1'b1, 32'hEEEEEEEE);
    idle(1);
    cycle(1'b1, 32'hDDDDDDDD, 1'b1, 32'hCCCCCCCC);
    idle(4);

    // Skew: lane 1 lags by 3 cycles
    do_reset();
    cycle(1'b1, 32'h00000003, 1'b0, '0);
    idle(2);
    cycle(1'b0, '0, 1'b1, 32'h00000004);
    idle(3);

    // Gap on lane 1 mid-stream
    cycle(1'b1, 32'h11111111, 1'b1, 32'h22222222);
    cycle(1'b1, 32'h33333333, 1'b0, '0);
    cycle(1'b1, 32'h55555555, 1'b0, '0);
    idle(2);
    cycle(1'b0, '0, 1'b1, 32'h99999999);
    idle(2);
    cycle(1'b0, '0, 1'b1, 32'h66666666);
    idle(3);

    // Overflow on lane 0 while unaligned
    do_reset();
    for (int i = 5; i <= 9; i++) cycle(1'b1, DW'(i), 1'b0, '0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 32'hB0000000 + DW'(i));
    idle(6);

    // Full lane 0 FIFO with push and pop on the same edge
    do_reset();
    cycle(1'b1, 32'hA0000000, 1'b1, 32'hB0000000);
    idle(2);
    for (int i = 1; i <= 5; i++) cycle(1'b1, 32'hA0000000 + DW'(i), 1'b0, '0);
    cycle(1'b0, '0, 1'b1, 32'hB0000001);
    idle(1);
    cycle(1'b1, 32'hA0000006, 1'b0, '0);
    for (int i = 2; i <= 6; i++) cycle(1'b0, '0, 1'b1, 32'hB0000000 + DW'(i));
    idle(6);

    // Asynchronous reset while both FIFOs hold data
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hC0000000 + DW'(i), 1'b1, 32'hD0000000 + DW'(i));
    @(negedge clk_2f);
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    #3;
    reset_L = 1'b0;
    model_reset();
    #1;
    check("async_data_out", data_out, '0);
    check("async_valid_out", {31'b0, valid_out}, '0);
    check("async_aligned", {31'b0, aligned}, '0);
    check("async_overflow_0", {31'b0, overflow_0}, '0);
    check("async_overflow_1", {31'b0, overflow_1}, '0);
    @(negedge clk_2f);
    reset_L = 1'b1;
    cycle(1'b1, 32'hAAAAAAAA, 1'b1, 32'hBBBBBBBB);
    idle(5);

    // Randomized traffic with occasional bursts and stalls
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 2) != 0), DW'($urandom), ($urandom_range(0, 2) != 0), DW'($urandom));
    end
    idle(12);

    @(negedge clk_2f);
    check("scoreboard_drained", DW'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
